hello_rd_credit_buf: RTL and testbench
======================================

# hello_rd_credit_buf

Credit-managed read-response buffer on the MPF read path between the FIU `c0Rx` port and the AFU write/compute stage. It grants read-issue permission only when a buffer slot is guaranteed, captures every read response (the FIU cannot be back-pressured), and presents the responses as a valid/ready stream to the downstream stage. It also exports outstanding-read and occupancy counts so the AFU state machine can detect quiescence.

## Interface
Parameters:
- `DEPTH`, 8: buffer entries and total credits; power of two, ≥2.
- `DATA_WIDTH`, 512: cache-line payload width.
- `MDATA_WIDTH`, 16: response mdata tag width.

Ports:
- `clk`  in  1  sole clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rd_req_sent`  in  1  one read request was accepted by the FIU this cycle.
- `can_issue`  out  1  at least one credit is available.
- `rsp_valid`  in  1  read response present (`cci_c0Rx_isReadRsp`).
- `rsp_data`  in  DATA_WIDTH  response line.
- `rsp_mdata`  in  MDATA_WIDTH  response tag.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  downstream accepts the head entry.
- `out_data`  out  DATA_WIDTH  head line.
- `out_mdata`  out  MDATA_WIDTH  head tag.
- `occupancy`  out  $clog2(DEPTH+1)  entries held.
- `outstanding`  out  $clog2(DEPTH+1)  reads issued, response not yet received.
- `err`  out  1  sticky protocol-violation flag.

## Operation
- `credits` register: reset to DEPTH. Decremented on `rd_req_sent`, incremented on dequeue (`out_valid && out_ready`). Both in the same cycle: unchanged.
- `can_issue` = (`credits` != 0), driven from registers only.
- `rd_req_sent` while `credits`==0: credits stay 0 and `err` sets.
- Enqueue on `rsp_valid`: write at `wr_ptr`, increment `wr_ptr` mod DEPTH and `occupancy`.
- Enqueue when full without a same-cycle dequeue: response dropped and `err` sets. Full with a same-cycle dequeue: enqueue accepted and `occupancy` unchanged.
- Dequeue: increment `rd_ptr` mod DEPTH, decrement `occupancy`.
- `outstanding` = DEPTH − `credits` − `occupancy`, computed combinationally and never negative.
- Credit increment that would exceed DEPTH: saturate at DEPTH and set `err`. This covers a response from a read issued before reset.
- Entries leave in arrival order. mdata is carried unchanged, and the block does not reorder responses.
- `err` clears only on reset.

## Timing
- Reset values: `credits`=DEPTH, `can_issue`=1, `out_valid`=0, `occupancy`=0, `outstanding`=0, `err`=0. Pointers are 0. Storage is not reset, so `out_data`/`out_mdata` are don't-care while `out_valid`=0.
- Response-to-`out_valid` latency: 1 cycle; there is no same-cycle bypass.
- `can_issue` reflects `rd_req_sent`/dequeue from the previous cycle (1-cycle update).
- `out_valid` holds, and `out_data` stays stable, until `out_ready` is sampled high at a rising edge.
- Reset asserted mid-operation clears all state immediately (asynchronously). The caller drains outstanding reads before reset; late responses are still enqueued and trip the saturate rule.
- Throughput: one enqueue and one dequeue per cycle, sustained.

## Structure
- Package `hello_rd_pkg`:
  - `t_rd_entry` struct {data, mdata}.
  - Default `DEPTH`.
  - Count-width localparam function.
- Sub-module `hello_rd_fifo_mem`: DEPTH×`t_rd_entry` storage with `wr_ptr`/`rd_ptr`, registered read, and full/empty flags.
- Top level holds the credit counter, the error logic and the `outstanding` calculation.

## Test plan
- Reset, then idle: `can_issue`=1, `out_valid`=0, `occupancy`=0, `outstanding`=0, `err`=0.
- 8 `rd_req_sent` pulses: `can_issue`=0 after the 8th and `outstanding`=8. Then 8 responses with mdata 0–7 and `out_ready`=0: `occupancy`=8, `outstanding`=0, head mdata=0.
- Drain at `out_ready`=1: mdata 0–7 emerge on consecutive cycles, data matches, and credits return to 8.
- Simultaneous `rd_req_sent`+dequeue at credits=0: credits stay 0, `err`=0. A 9th issue with no dequeue: `err`=1.
- Full buffer, then `rsp_valid` with `out_ready`=0: entry dropped and `err`=1. Same stimulus with `out_ready`=1: entry accepted, `occupancy` stays 8.
- Assert `reset_n` low with 3 reads outstanding, release it, then deliver 1 late response: `occupancy`=1. Dequeue it: credits saturate at 8 and `err`=1.

Source files
------------

// File: rtl/hello_rd_pkg.sv
// ============================================================================
// Module      : hello_rd_pkg
// Description : Shared types, defaults and helpers for the read-credit buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hello_rd_pkg;

    localparam int c_default_depth       = 8;
    localparam int c_default_data_width  = 512;
    localparam int c_default_mdata_width = 16;

    typedef struct packed {
        logic [c_default_data_width-1:0]  data;
        logic [c_default_mdata_width-1:0] mdata;
    } t_rd_entry;

    // Width able to hold every value 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/hello_rd_fifo_mem.sv
// ============================================================================
// Module      : hello_rd_fifo_mem
// Description : DEPTH-entry response store with registered head read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hello_rd_fifo_mem
    import hello_rd_pkg::*;
#(
    parameter int DEPTH       = c_default_depth,
    parameter int DATA_WIDTH  = c_default_data_width,
    parameter int MDATA_WIDTH = c_default_mdata_width
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          wr_en,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic [MDATA_WIDTH-1:0]        wr_mdata,
    input  logic                          rd_en,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic [MDATA_WIDTH-1:0]        rd_mdata,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          full,
    output logic                          empty
);

    localparam int                 c_ptr_w = $clog2(DEPTH);
    localparam int                 c_cnt_w = count_width(DEPTH);
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]  data;
        logic [MDATA_WIDTH-1:0] mdata;
    } t_entry;

    t_entry             r_mem [DEPTH];
    t_entry             r_head;
    t_entry             w_wr_entry;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] w_rd_ptr_nxt;
    logic [c_cnt_w-1:0] r_count;
    logic               w_wr_ok;
    logic               w_rd_ok;

    assign full  = (r_count == c_depth);
    assign empty = (r_count == '0);
    assign count = r_count;

    assign w_rd_ok      = rd_en && !empty;
    assign w_wr_ok      = wr_en && (!full || w_rd_ok);
    assign w_wr_entry   = '{data: wr_data, mdata: wr_mdata};
    assign w_rd_ptr_nxt = w_rd_ok ? (r_rd_ptr + c_ptr_w'(1)) : r_rd_ptr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            r_rd_ptr <= w_rd_ptr_nxt;
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // The head slot is being written only when the queue is otherwise empty,
    // so forward the incoming entry straight into the head register.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
        r_head <= (w_wr_ok && (r_wr_ptr == w_rd_ptr_nxt)) ? w_wr_entry : r_mem[w_rd_ptr_nxt];
    end

    assign rd_data  = r_head.data;
    assign rd_mdata = r_head.mdata;

endmodule

`default_nettype wire

// File: rtl/hello_rd_credit_buf.sv
// ============================================================================
// Module      : hello_rd_credit_buf
// Description : Credit-gated read-response buffer with quiescence counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hello_rd_credit_buf
    import hello_rd_pkg::*;
#(
    parameter int DEPTH       = c_default_depth,
    parameter int DATA_WIDTH  = c_default_data_width,
    parameter int MDATA_WIDTH = c_default_mdata_width
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          rd_req_sent,
    output logic                          can_issue,
    input  logic                          rsp_valid,
    input  logic [DATA_WIDTH-1:0]         rsp_data,
    input  logic [MDATA_WIDTH-1:0]        rsp_mdata,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [MDATA_WIDTH-1:0]        out_mdata,
    output logic [count_width(DEPTH)-1:0] occupancy,
    output logic [count_width(DEPTH)-1:0] outstanding,
    output logic                          err
);

    localparam int                 c_cnt_w = count_width(DEPTH);
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

    logic [c_cnt_w-1:0] r_credits;
    logic [c_cnt_w-1:0] w_credits_nxt;
    logic               r_err;
    logic               w_err_nxt;
    logic               w_full;
    logic               w_empty;
    logic               w_deq;
    logic               w_enq;
    logic [c_cnt_w:0]   w_outstanding_raw;

    assign out_valid = !w_empty;
    assign w_deq     = out_valid && out_ready;
    assign w_enq     = rsp_valid && (!w_full || w_deq);

    hello_rd_fifo_mem #(
        .DEPTH       (DEPTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .MDATA_WIDTH (MDATA_WIDTH)
    ) u_fifo_mem (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (w_enq),
        .wr_data  (rsp_data),
        .wr_mdata (rsp_mdata),
        .rd_en    (w_deq),
        .rd_data  (out_data),
        .rd_mdata (out_mdata),
        .count    (occupancy),
        .full     (w_full),
        .empty    (w_empty)
    );

    always_comb begin
        w_credits_nxt = r_credits;
        w_err_nxt     = r_err;
        if (rsp_valid && w_full && !w_deq) begin
            w_err_nxt = 1'b1;
        end
        case ({rd_req_sent, w_deq})
            2'b10: begin
                if (r_credits == '0) begin
                    w_err_nxt = 1'b1;
                end else begin
                    w_credits_nxt = r_credits - c_cnt_w'(1);
                end
            end
            2'b01: begin
                // A return beyond DEPTH comes from a read issued before reset.
                if (r_credits == c_depth) begin
                    w_err_nxt = 1'b1;
                end else begin
                    w_credits_nxt = r_credits + c_cnt_w'(1);
                end
            end
            default: begin
                w_credits_nxt = r_credits;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_credits <= c_depth;
            r_err     <= 1'b0;
        end else begin
            r_credits <= w_credits_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign can_issue = (r_credits != '0);
    assign err       = r_err;

    // Late pre-reset responses can drive the difference below zero; clamp it.
    assign w_outstanding_raw = {1'b0, c_depth} - {1'b0, r_credits} - {1'b0, occupancy};
    assign outstanding       = w_outstanding_raw[c_cnt_w] ? '0 : w_outstanding_raw[c_cnt_w-1:0];

endmodule

`default_nettype wire

// File: tb/tb_hello_rd_credit_buf.sv
// ============================================================================
// Module      : tb_hello_rd_credit_buf
// Description : Directed scoreboard bench for hello_rd_credit_buf.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hello_rd_credit_buf;
    import hello_rd_pkg::*;

    localparam int c_depth = 8;
    localparam int c_dw    = 512;
    localparam int c_mw    = 16;
    localparam int c_cw    = $clog2(c_depth + 1);

    logic              clk         = 1'b0;
    logic              reset_n     = 1'b0;
    logic              rd_req_sent = 1'b0;
    logic              rsp_valid   = 1'b0;
    logic              out_ready   = 1'b0;
    logic [c_dw-1:0]   rsp_data    = '0;
    logic [c_mw-1:0]   rsp_mdata   = '0;
    logic              can_issue;
    logic              out_valid;
    logic [c_dw-1:0]   out_data;
    logic [c_mw-1:0]   out_mdata;
    logic [c_cw-1:0]   occupancy;
    logic [c_cw-1:0]   outstanding;
    logic              err;

    int        n_total = 0;
    int        n_pass  = 0;
    t_rd_entry sb[$];

    always #5 clk = ~clk;

    hello_rd_credit_buf #(
        .DEPTH       (c_depth),
        .DATA_WIDTH  (c_dw),
        .MDATA_WIDTH (c_mw)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rd_req_sent (rd_req_sent),
        .can_issue   (can_issue),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_mdata   (rsp_mdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_mdata   (out_mdata),
        .occupancy   (occupancy),
        .outstanding (outstanding),
        .err         (err)
    );

    task automatic check(input string tag, input logic [c_dw-1:0] obs, input logic [c_dw-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cycle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic issue(input int n);
        rd_req_sent = 1'b1;
        cycle(n);
        rd_req_sent = 1'b0;
    endtask

    task automatic load_rsp(input logic [c_mw-1:0] m, input bit keep);
        logic [c_dw-1:0] d;
        for (int k = 0; k < c_dw / 32; k++) d[k*32 +: 32] = $urandom();
        rsp_data  = d;
        rsp_mdata = m;
        rsp_valid = 1'b1;
        if (keep) sb.push_back('{data: d, mdata: m});
    endtask

    task automatic send_rsp(input logic [c_mw-1:0] m, input bit keep);
        load_rsp(m, keep);
        cycle(1);
        rsp_valid = 1'b0;
    endtask

    // Compare the presented head against the oldest expected entry.
    task automatic pop_cmp();
        t_rd_entry e;
        check("deq_valid", out_valid, 1'b1);
        if (sb.size() == 0) begin
            n_total++;
            $error("FAIL sb_underflow: observed dequeue expected empty scoreboard");
        end else begin
            e = sb.pop_front();
            check("head_mdata", out_mdata, e.mdata);
            check("head_data", out_data, e.data);
        end
    endtask

    task automatic drain(input int n);
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            pop_cmp();
            cycle(1);
        end
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cycle(1);
        reset_n = 1'b1;
        cycle(1);
        sb.delete();
    endtask

    initial begin
        cycle(2);
        reset_n = 1'b1;
        cycle(2);
        check("idle_can_issue", can_issue, 1'b1);
        check("idle_out_valid", out_valid, 1'b0);
        check("idle_occupancy", occupancy, 0);
        check("idle_outstanding", outstanding, 0);
        check("idle_err", err, 1'b0);

        // Consume every credit, then return all responses without dequeuing.
        issue(7);
        check("can_issue_after7", can_issue, 1'b1);
        issue(1);
        check("can_issue_after8", can_issue, 1'b0);
        check("outstanding_8", outstanding, 8);
        send_rsp(16'd0, 1'b1);
        check("latency_out_valid", out_valid, 1'b1);
        check("latency_occupancy", occupancy, 1);
        check("latency_outstanding", outstanding, 7);
        for (int i = 1; i < 8; i++) send_rsp(16'(i), 1'b1);
        cycle(2);
        check("full_occupancy", occupancy, 8);
        check("full_outstanding", outstanding, 0);
        check("hold_out_valid", out_valid, 1'b1);
        check("hold_head_mdata", out_mdata, 16'd0);

        drain(8);
        check("drained_out_valid", out_valid, 1'b0);
        check("drained_occupancy", occupancy, 0);
        check("drained_outstanding", outstanding, 0);
        check("drained_can_issue", can_issue, 1'b1);
        check("drained_err", err, 1'b0);

        // Issue and dequeue together while out of credits.
        issue(8);
        send_rsp(16'h0020, 1'b1);
        check("simul_pre_occupancy", occupancy, 1);
        check("simul_pre_outstanding", outstanding, 7);
        rd_req_sent = 1'b1;
        out_ready   = 1'b1;
        pop_cmp();
        cycle(1);
        rd_req_sent = 1'b0;
        out_ready   = 1'b0;
        check("simul_can_issue", can_issue, 1'b0);
        check("simul_err", err, 1'b0);
        check("simul_outstanding", outstanding, 8);
        issue(1);
        check("overissue_err", err, 1'b1);
        check("overissue_can_issue", can_issue, 1'b0);

        do_reset();
        check("reset_err_clear", err, 1'b0);
        check("reset_can_issue", can_issue, 1'b1);

        // Overflow: dropped without a dequeue, accepted with one.
        issue(8);
        for (int i = 0; i < 8; i++) send_rsp(16'(16'h0030 + i), 1'b1);
        check("ovf_pre_err", err, 1'b0);
        send_rsp(16'hDEAD, 1'b0);
        check("drop_err", err, 1'b1);
        check("drop_occupancy", occupancy, 8);
        out_ready = 1'b1;
        pop_cmp();
        load_rsp(16'h0BEE, 1'b1);
        cycle(1);
        rsp_valid = 1'b0;
        out_ready = 1'b0;
        check("accept_occupancy", occupancy, 8);
        drain(8);
        check("ovf_drained_occupancy", occupancy, 0);

        // Late response after a reset with reads in flight.
        do_reset();
        issue(3);
        check("pre_reset_outstanding", outstanding, 3);
        reset_n = 1'b0;
        #1;
        check("async_reset_outstanding", outstanding, 0);
        check("async_reset_can_issue", can_issue, 1'b1);
        cycle(1);
        reset_n = 1'b1;
        cycle(1);
        send_rsp(16'h0ABC, 1'b1);
        check("late_occupancy", occupancy, 1);
        check("late_outstanding", outstanding, 0);
        check("late_err_pre", err, 1'b0);
        drain(1);
        check("saturate_err", err, 1'b1);
        check("saturate_can_issue", can_issue, 1'b1);
        check("saturate_occupancy", occupancy, 0);
        check("saturate_outstanding", outstanding, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
